// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: sequencer FSM states,
// default widths and the jump-target builder.
package cpu_pkg;

    localparam int unsigned PM_ADDR_W_DEF  = 8;
    localparam int unsigned JMP_ADDR_W_DEF = 4;
    localparam int unsigned CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        PS_RUN,
        PS_BREAK,
        PS_STEP,
        PS_RESUME
    } ps_state_t;

    // Jump target: the decoder nibble lands in the top bits of the PC,
    // lower bits are zero. Caller truncates to its own PC width.
    function automatic logic [31:0] build_target(input logic [31:0] nibble,
                                                 input int unsigned shift);
        return nibble << shift;
    endfunction

endpackage

// File: rtl/ps_break_ctrl.sv
// Breakpoint / single-step controller: tracks run/halt state and
// decides whether the instruction currently in ir may execute.
module ps_break_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned PM_ADDR_W = PM_ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 sync_reset_n,
    input  logic                 hold,
    input  logic                 bp_en,
    input  logic [PM_ADDR_W-1:0] bp_addr,
    input  logic                 step,
    input  logic                 resume,
    input  logic [PM_ADDR_W-1:0] pc,
    output logic                 squash,
    output logic                 halted
);

    ps_state_t state;
    logic      bp_hit;

    assign bp_hit = bp_en && (pc == bp_addr);

    // Run/break state machine; STEP and RESUME let exactly one instruction
    // through with the breakpoint compare disabled, waiting out any hold.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state <= PS_RUN;
        end else begin
            case (state)
                PS_RUN: begin
                    if (bp_hit) state <= PS_BREAK;
                end
                PS_BREAK: begin
                    if (resume)    state <= PS_RESUME;
                    else if (step) state <= PS_STEP;
                end
                PS_STEP: begin
                    if (!hold) state <= PS_BREAK;
                end
                PS_RESUME: begin
                    if (!hold) state <= PS_RUN;
                end
                default: state <= PS_RUN;
            endcase
        end
    end

    // Squash the ir instruction on stall, while halted, or on a fresh breakpoint hit.
    always_comb begin
        squash = hold || (state == PS_BREAK) || ((state == PS_RUN) && bp_hit);
        halted = (state == PS_BREAK);
    end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: owns the PC, drives the synchronous program-ROM
// address, applies decoder jumps and counts retired instructions.
module program_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PM_ADDR_W  = PM_ADDR_W_DEF,
    parameter int unsigned JMP_ADDR_W = JMP_ADDR_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  sync_reset_n,
    input  logic                  jmp,
    input  logic                  jmp_nz,
    input  logic [JMP_ADDR_W-1:0] jmp_addr,
    input  logic                  dont_jmp,
    input  logic                  hold,
    input  logic                  bp_en,
    input  logic [PM_ADDR_W-1:0]  bp_addr,
    input  logic                  step,
    input  logic                  resume,
    output logic [PM_ADDR_W-1:0]  pm_addr,
    output logic [PM_ADDR_W-1:0]  pc,
    output logic                  squash,
    output logic                  halted,
    output logic [CNT_W-1:0]      retired_cnt
);

    localparam int unsigned TGT_SHIFT = PM_ADDR_W - JMP_ADDR_W;

    logic [PM_ADDR_W-1:0] target;

    assign target = PM_ADDR_W'(build_target(32'(jmp_addr), TGT_SHIFT));

    ps_break_ctrl #(
        .PM_ADDR_W (PM_ADDR_W)
    ) u_break_ctrl (
        .clk          (clk),
        .sync_reset_n (sync_reset_n),
        .hold         (hold),
        .bp_en        (bp_en),
        .bp_addr      (bp_addr),
        .step         (step),
        .resume       (resume),
        .pc           (pc),
        .squash       (squash),
        .halted       (halted)
    );

    // Next-PC mux: reset, refetch on squash, jumps, then sequential increment.
    always_comb begin
        pm_addr = pc + PM_ADDR_W'(1);
        if (!sync_reset_n) begin
            pm_addr = '0;
        end else if (squash) begin
            pm_addr = pc;
        end else if (jmp) begin
            pm_addr = target;
        end else if (jmp_nz && !dont_jmp) begin
            pm_addr = target;
        end
    end

    // PC follows the fetch address so it always names the instruction in ir.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) pc <= '0;
        else               pc <= pm_addr;
    end

    // Count every instruction that is allowed to execute.
    always_ff @(posedge clk) begin
        if (!sync_reset_n)  retired_cnt <= '0;
        else if (!squash)   retired_cnt <= retired_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed vector table followed by
// randomized stimulus checked against a behavioural model.
module tb_program_sequencer;

    logic       clk;
    logic       sync_reset_n;
    logic       jmp, jmp_nz, dont_jmp, hold, bp_en, step, resume;
    logic [3:0] jmp_addr;
    logic [7:0] bp_addr;
    logic [7:0] pm_addr, pc;
    logic       squash, halted;
    logic [15:0] retired_cnt;

    int checks = 0;
    int failures = 0;

    program_sequencer dut (
        .clk          (clk),
        .sync_reset_n (sync_reset_n),
        .jmp          (jmp),
        .jmp_nz       (jmp_nz),
        .jmp_addr     (jmp_addr),
        .dont_jmp     (dont_jmp),
        .hold         (hold),
        .bp_en        (bp_en),
        .bp_addr      (bp_addr),
        .step         (step),
        .resume       (resume),
        .pm_addr      (pm_addr),
        .pc           (pc),
        .squash       (squash),
        .halted       (halted),
        .retired_cnt  (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, jmp, jmp_nz;
        logic [3:0] ja;
        logic       dj, hold, bpe;
        logic [7:0] bpa;
        logic       step, resume;
        logic [7:0] e_pm, e_pc;
        logic       e_sq, e_h;
        logic [15:0] e_cnt;
        logic       chk_flags;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst_n, input logic j, input logic jnz,
                                input logic [3:0] ja, input logic dj, input logic hd,
                                input logic bpe, input logic [7:0] bpa,
                                input logic st, input logic rs,
                                input logic [7:0] e_pm, input logic [7:0] e_pc,
                                input logic e_sq, input logic e_h, input logic [15:0] e_cnt);
        vec_t v;
        v.rst_n = rst_n; v.jmp = j; v.jmp_nz = jnz; v.ja = ja; v.dj = dj; v.hold = hd;
        v.bpe = bpe; v.bpa = bpa; v.step = st; v.resume = rs;
        v.e_pm = e_pm; v.e_pc = e_pc; v.e_sq = e_sq; v.e_h = e_h; v.e_cnt = e_cnt;
        v.chk_flags = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        sync_reset_n = v.rst_n; jmp = v.jmp; jmp_nz = v.jmp_nz; jmp_addr = v.ja;
        dont_jmp = v.dj; hold = v.hold; bp_en = v.bpe; bp_addr = v.bpa;
        step = v.step; resume = v.resume;
    endtask

    task automatic build_table();
        vec_t v;
        // reset held, jmp during reset must not leak into pm_addr
        tbl.push_back(mk(0,0,0,0,0,0,0,8'h00,0,0, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,8'h00,0,0, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(0,1,0,4'hF,0,0,0,8'h00,0,0, 8'h00,8'h00,0,0,0));
        // release: pc 0,1,2,3,4
        tbl.push_back(mk(1,0,0,0,0,0,0,8'h00,0,0, 8'h01,8'h00,0,0,0));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(mk(1,0,0,0,0,0,0,8'h00,0,0, 8'(k+1),8'(k),0,0,16'(k)));
        // jmp at pc=5 to A0, then to F0 and run across the wrap
        tbl.push_back(mk(1,1,0,4'hA,0,0,0,8'h00,0,0, 8'hA0,8'h05,0,0,5));
        tbl.push_back(mk(1,1,0,4'hF,0,0,0,8'h00,0,0, 8'hF0,8'hA0,0,0,6));
        for (int k = 0; k <= 15; k++)
            tbl.push_back(mk(1,0,0,0,0,0,0,8'h00,0,0, 8'(8'hF1+k),8'(8'hF0+k),0,0,16'(7+k)));
        for (int k = 0; k <= 6; k++)
            tbl.push_back(mk(1,0,0,0,0,0,0,8'h00,0,0, 8'(k+1),8'(k),0,0,16'(23+k)));
        // jmp_nz blocked, then taken
        tbl.push_back(mk(1,0,1,4'h3,1,0,0,8'h00,0,0, 8'h08,8'h07,0,0,30));
        tbl.push_back(mk(1,0,1,4'h3,0,0,0,8'h00,0,0, 8'h30,8'h08,0,0,31));
        tbl.push_back(mk(1,0,0,0,0,0,0,8'h00,0,0, 8'h31,8'h30,0,0,32));
        tbl.push_back(mk(0,0,0,0,0,0,0,8'h00,0,0, 8'h00,8'h31,0,0,33));
        for (int k = 0; k <= 8; k++)
            tbl.push_back(mk(1,0,0,0,0,0,0,8'h00,0,0, 8'(k+1),8'(k),0,0,16'(k)));
        // hold for 2 clks with jmp pending, then jump taken
        tbl.push_back(mk(1,1,0,4'h5,0,1,0,8'h00,0,0, 8'h09,8'h09,1,0,9));
        tbl.push_back(mk(1,1,0,4'h5,0,1,0,8'h00,0,0, 8'h09,8'h09,1,0,9));
        tbl.push_back(mk(1,1,0,4'h5,0,0,0,8'h00,0,0, 8'h50,8'h09,0,0,9));
        tbl.push_back(mk(1,0,0,0,0,0,0,8'h00,0,0, 8'h51,8'h50,0,0,10));
        // breakpoint at 12, step, resume
        tbl.push_back(mk(1,1,0,4'h1,0,0,1,8'h12,0,0, 8'h10,8'h51,0,0,11));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h12,0,0, 8'h11,8'h10,0,0,12));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h12,0,0, 8'h12,8'h11,0,0,13));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h12,0,0, 8'h12,8'h12,1,0,14));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h12,0,0, 8'h12,8'h12,1,1,14));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h12,1,0, 8'h12,8'h12,1,1,14));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h12,0,0, 8'h13,8'h12,0,0,14));
        tbl.push_back(mk(1,1,0,4'h7,0,0,1,8'h12,0,0, 8'h13,8'h13,1,1,15));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h12,0,1, 8'h13,8'h13,1,1,15));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h12,0,0, 8'h14,8'h13,0,0,15));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h12,0,0, 8'h15,8'h14,0,0,16));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h12,0,0, 8'h16,8'h15,0,0,17));
        // halt at 16, reset while halted
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h16,0,0, 8'h16,8'h16,1,0,18));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h16,0,0, 8'h16,8'h16,1,1,18));
        v = mk(0,0,0,0,0,0,1,8'h16,0,0, 8'h00,8'h16,1,1,18);
        v.chk_flags = 1'b0;
        tbl.push_back(v);
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h16,0,0, 8'h01,8'h00,0,0,0));
        // halt at 01, step and resume together -> resume wins
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h01,0,0, 8'h01,8'h01,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h01,0,0, 8'h01,8'h01,1,1,1));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h01,1,1, 8'h01,8'h01,1,1,1));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h01,0,0, 8'h02,8'h01,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h01,0,0, 8'h03,8'h02,0,0,2));
        // halt at 03, step stalled by hold, then completes
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h03,0,0, 8'h03,8'h03,1,0,3));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h03,0,0, 8'h03,8'h03,1,1,3));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h03,1,0, 8'h03,8'h03,1,1,3));
        tbl.push_back(mk(1,0,0,0,0,1,1,8'h03,0,0, 8'h03,8'h03,1,0,3));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h03,0,0, 8'h04,8'h03,0,0,3));
        tbl.push_back(mk(1,0,0,0,0,0,1,8'h03,0,0, 8'h04,8'h04,1,1,4));
    endtask

    // Behavioural model state
    int m_pc, m_cnt;
    bit m_halt;      // stopped at a breakpoint
    bit m_granted;   // one instruction released from halt, bp compare suppressed
    bit m_to_run;    // after the granted instruction, keep running

    initial begin
        vec_t v;
        int exp_pm, tgt;
        bit exp_sq, hit;
        sync_reset_n = 1'b0; jmp = 0; jmp_nz = 0; jmp_addr = '0; dont_jmp = 0;
        hold = 0; bp_en = 0; bp_addr = '0; step = 0; resume = 0;
        @(posedge clk); #1;

        build_table();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("row%0d pm_addr", i), 32'(pm_addr), 32'(tbl[i].e_pm));
            check($sformatf("row%0d pc", i), 32'(pc), 32'(tbl[i].e_pc));
            check($sformatf("row%0d retired_cnt", i), 32'(retired_cnt), 32'(tbl[i].e_cnt));
            if (tbl[i].chk_flags) begin
                check($sformatf("row%0d squash", i), 32'(squash), 32'(tbl[i].e_sq));
                check($sformatf("row%0d halted", i), 32'(halted), 32'(tbl[i].e_h));
            end
            @(posedge clk); #1;
        end

        // Randomized phase
        sync_reset_n = 1'b0; hold = 0; step = 0; resume = 0; jmp = 0; jmp_nz = 0;
        @(posedge clk); #1;
        m_pc = 0; m_cnt = 0; m_halt = 0; m_granted = 0; m_to_run = 0;
        for (int n = 0; n < 3000; n++) begin
            sync_reset_n = ($urandom_range(0, 99) != 0);
            jmp      = ($urandom_range(0, 9) == 0);
            jmp_nz   = ($urandom_range(0, 6) == 0);
            jmp_addr = 4'($urandom);
            dont_jmp = 1'($urandom);
            hold     = ($urandom_range(0, 9) == 0);
            bp_en    = 1'($urandom);
            bp_addr  = 8'(m_pc + $urandom_range(0, 4));
            step     = ($urandom_range(0, 11) == 0);
            resume   = ($urandom_range(0, 11) == 0);
            @(negedge clk);

            hit = bp_en && (m_pc == int'(bp_addr));
            exp_sq = hold || m_halt || (!m_halt && !m_granted && hit);
            tgt = int'(jmp_addr) * 16;
            if (!sync_reset_n)              exp_pm = 0;
            else if (exp_sq)                exp_pm = m_pc;
            else if (jmp)                   exp_pm = tgt;
            else if (jmp_nz && !dont_jmp)   exp_pm = tgt;
            else                            exp_pm = (m_pc + 1) % 256;

            check($sformatf("rnd%0d pm_addr", n), 32'(pm_addr), 32'(exp_pm));
            check($sformatf("rnd%0d pc", n), 32'(pc), 32'(m_pc));
            check($sformatf("rnd%0d retired_cnt", n), 32'(retired_cnt), 32'(m_cnt));
            if (sync_reset_n) begin
                check($sformatf("rnd%0d squash", n), 32'(squash), 32'(exp_sq));
                check($sformatf("rnd%0d halted", n), 32'(halted), 32'(m_halt));
            end

            @(posedge clk);
            if (!sync_reset_n) begin
                m_pc = 0; m_cnt = 0; m_halt = 0; m_granted = 0; m_to_run = 0;
            end else begin
                m_pc = exp_pm;
                if (!exp_sq) m_cnt = (m_cnt + 1) % 65536;
                if (m_halt) begin
                    if (resume) begin
                        m_halt = 0; m_granted = 1; m_to_run = 1;
                    end else if (step) begin
                        m_halt = 0; m_granted = 1; m_to_run = 0;
                    end
                end else if (m_granted) begin
                    if (!hold) begin
                        m_granted = 0;
                        m_halt = !m_to_run;
                    end
                end else if (hit) begin
                    m_halt = 1;
                end
            end
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
